// File: rtl/life_sequencer_if.sv
// rtl/life_sequencer_if.sv - control, status and field-array signals of the life sequencer
interface life_sequencer_if #(
    parameter int SIZE      = 10,
    parameter int DIV_WIDTH = 16,
    parameter int GEN_WIDTH = 16
);
    logic                   run;
    logic                   step;
    logic                   load;
    logic [DIV_WIDTH-1:0]   period;
    logic [SIZE*SIZE-1:0]   field;
    logic                   life_clk;
    logic                   life_rst;
    logic [GEN_WIDTH-1:0]   generation;
    logic                   running;
    logic                   halted;
    logic [1:0]             halt_reason;

    modport master (
        output run, step, load, period, field,
        input  life_clk, life_rst, generation, running, halted, halt_reason
    );

    modport slave (
        input  run, step, load, period, field,
        output life_clk, life_rst, generation, running, halted, halt_reason
    );
endinterface

// File: rtl/life_sequencer.sv
// rtl/life_sequencer.sv - Game of Life generation controller; LIFE_STABLE_HALT_EN enables stable-field halt
module life_sequencer #(
    parameter int SIZE      = 10,
    parameter int DIV_WIDTH = 16,
    parameter int GEN_WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    life_sequencer_if.slave bus
);
    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_LOAD_SETUP = 4'd1;
    localparam logic [3:0] S_LOAD_TICK  = 4'd2;
    localparam logic [3:0] S_LOAD_HOLD  = 4'd3;
    localparam logic [3:0] S_RUN_WAIT   = 4'd4;
    localparam logic [3:0] S_TICK       = 4'd5;
    localparam logic [3:0] S_SETTLE     = 4'd6;
    localparam logic [3:0] S_EVAL       = 4'd7;
    localparam logic [3:0] S_HALT       = 4'd8;

    logic [3:0]           state, state_d;
    logic                 run_mode, run_mode_d;
    logic [DIV_WIDTH-1:0] wait_cnt, wait_d, period_m1;
    logic [GEN_WIDTH-1:0] generation, gen_d, gen_inc;
    logic [1:0]           halt_reason, reason_d;
    logic                 step_q, load_q;
    logic                 step_edge, load_edge;
    logic                 life_clk_q, life_rst_q, running_q, halted_q;
`ifdef LIFE_STABLE_HALT_EN
    logic [SIZE*SIZE-1:0] snapshot, snap_d;
`endif

    assign step_edge = bus.step & ~step_q;
    assign load_edge = bus.load & ~load_q;
    // A zero period behaves like one wait cycle.
    assign period_m1 = (bus.period == '0) ? '0 : bus.period - DIV_WIDTH'(1);
    assign gen_inc   = generation + GEN_WIDTH'(1);

    always_comb begin
        state_d    = state;
        run_mode_d = run_mode;
        wait_d     = wait_cnt;
        gen_d      = generation;
        reason_d   = halt_reason;
`ifdef LIFE_STABLE_HALT_EN
        snap_d     = snapshot;
`endif
        case (state)
            S_IDLE: begin
                if (load_edge) begin
                    state_d = S_LOAD_SETUP;
                end else if (step_edge) begin
                    state_d    = S_TICK;
                    run_mode_d = 1'b0;
                end else if (bus.run) begin
                    state_d    = S_RUN_WAIT;
                    run_mode_d = 1'b1;
                    wait_d     = period_m1;
                end
            end
            S_LOAD_SETUP: state_d = S_LOAD_TICK;
            S_LOAD_TICK:  state_d = S_LOAD_HOLD;
            S_LOAD_HOLD: begin
                state_d    = S_IDLE;
                run_mode_d = 1'b0;
                gen_d      = '0;
                reason_d   = 2'b00;
`ifdef LIFE_STABLE_HALT_EN
                snap_d     = bus.field;
`endif
            end
            S_RUN_WAIT: begin
                if (load_edge) begin
                    state_d = S_LOAD_SETUP;
                end else if (!bus.run) begin
                    state_d    = S_IDLE;
                    run_mode_d = 1'b0;
                end else if (wait_cnt == '0) begin
                    state_d = S_TICK;
                end else begin
                    wait_d = wait_cnt - DIV_WIDTH'(1);
                end
            end
            S_TICK:   state_d = S_SETTLE;
            S_SETTLE: state_d = S_EVAL;
            S_EVAL: begin
                gen_d = gen_inc;
                // Halt checks are ordered: extinction, stability, counter limit.
                if (bus.field == '0) begin
                    state_d    = S_HALT;
                    run_mode_d = 1'b0;
                    reason_d   = 2'b01;
`ifdef LIFE_STABLE_HALT_EN
                end else if (bus.field == snapshot) begin
                    state_d    = S_HALT;
                    run_mode_d = 1'b0;
                    reason_d   = 2'b10;
`endif
                end else if (gen_inc == '1) begin
                    state_d    = S_HALT;
                    run_mode_d = 1'b0;
                    reason_d   = 2'b11;
                end else begin
`ifdef LIFE_STABLE_HALT_EN
                    snap_d = bus.field;
`endif
                    if (run_mode && bus.run) begin
                        state_d = S_RUN_WAIT;
                        wait_d  = period_m1;
                    end else begin
                        state_d    = S_IDLE;
                        run_mode_d = 1'b0;
                    end
                end
            end
            S_HALT: begin
                if (load_edge) begin
                    state_d = S_LOAD_SETUP;
                end
            end
            default: begin
                state_d    = S_IDLE;
                run_mode_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            run_mode    <= 1'b0;
            wait_cnt    <= '0;
            generation  <= '0;
            halt_reason <= 2'b00;
            step_q      <= 1'b0;
            load_q      <= 1'b0;
            life_clk_q  <= 1'b0;
            life_rst_q  <= 1'b0;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
`ifdef LIFE_STABLE_HALT_EN
            snapshot    <= '0;
`endif
        end else begin
            state       <= state_d;
            run_mode    <= run_mode_d;
            wait_cnt    <= wait_d;
            generation  <= gen_d;
            halt_reason <= reason_d;
            step_q      <= bus.step;
            load_q      <= bus.load;
            // Field strobes are registered from the next state so they never glitch.
            life_clk_q  <= (state_d == S_TICK) || (state_d == S_LOAD_TICK);
            life_rst_q  <= state_d inside {S_LOAD_SETUP, S_LOAD_TICK, S_LOAD_HOLD};
            running_q   <= run_mode_d && (state_d inside {S_RUN_WAIT, S_TICK, S_SETTLE, S_EVAL});
            halted_q    <= (state_d == S_HALT);
`ifdef LIFE_STABLE_HALT_EN
            snapshot    <= snap_d;
`endif
        end
    end

    assign bus.life_clk    = life_clk_q;
    assign bus.life_rst    = life_rst_q;
    assign bus.generation  = generation;
    assign bus.running     = running_q;
    assign bus.halted      = halted_q;
    assign bus.halt_reason = halt_reason;
endmodule

// File: tb/tb_life_sequencer.sv
// tb/tb_life_sequencer.sv - directed self-checking bench for life_sequencer with a Life field model
module tb_life_sequencer;
    localparam int SZ = 10;
    localparam int N  = SZ * SZ;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    life_sequencer_if #(.SIZE(SZ), .DIV_WIDTH(DW), .GEN_WIDTH(16)) i0();
    life_sequencer_if #(.SIZE(SZ), .DIV_WIDTH(DW), .GEN_WIDTH(3))  i1();

    life_sequencer #(.SIZE(SZ), .DIV_WIDTH(DW), .GEN_WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(i0)
    );
    life_sequencer #(.SIZE(SZ), .DIV_WIDTH(DW), .GEN_WIDTH(3)) u_lim (
        .clk(clk), .rst_n(rst_n), .bus(i1)
    );

    function automatic logic [N-1:0] life_next(input logic [N-1:0] f);
        logic [N-1:0] nf;
        int cnt;
        nf = '0;
        for (int r = 0; r < SZ; r++) begin
            for (int c = 0; c < SZ; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < SZ && c + dc >= 0 && c + dc < SZ)
                            cnt += int'(f[(r + dr) * SZ + c + dc]);
                nf[r * SZ + c] = (cnt == 3) || (f[r * SZ + c] && cnt == 2);
            end
        end
        return nf;
    endfunction

    logic [N-1:0] sw0 = '0, fld0 = '0, sw1 = '0, fld1 = '0;
    always @(posedge i0.life_clk) fld0 <= i0.life_rst ? sw0 : life_next(fld0);
    always @(posedge i1.life_clk) fld1 <= i1.life_rst ? sw1 : life_next(fld1);
    assign i0.field = fld0;
    assign i1.field = fld1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic count_pulses(input bit which, input int cycles, output int p);
        p = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            p += which ? int'(i1.life_clk) : int'(i0.life_clk);
        end
    endtask

    task automatic load0(input logic [N-1:0] pat);
        sw0 = pat;
        i0.load = 1'b1;
        @(negedge clk);
        i0.load = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic load1(input logic [N-1:0] pat);
        sw1 = pat;
        i1.load = 1'b1;
        @(negedge clk);
        i1.load = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    logic [N-1:0] blinker, single, block;
    int er[4] = '{1, 1, 1, 0};
    int ec[4] = '{0, 1, 0, 0};
    int pulses, last, p;

    initial begin
        blinker = '0; blinker[43] = 1'b1; blinker[44] = 1'b1; blinker[45] = 1'b1;
        single  = '0; single[55] = 1'b1;
        block   = '0; block[44] = 1'b1; block[45] = 1'b1; block[54] = 1'b1; block[55] = 1'b1;
        i0.run = 1'b1; i0.step = 1'b0; i0.load = 1'b0; i0.period = '0;
        i1.run = 1'b0; i1.step = 1'b0; i1.load = 1'b0; i1.period = '0;

        // reset held with run high
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_eq("rst_life_clk", i0.life_clk, 0);
            check_eq("rst_life_rst", i0.life_rst, 0);
        end
        check_eq("rst_generation", i0.generation, 0);
        check_eq("rst_running", i0.running, 0);
        check_eq("rst_halted", i0.halted, 0);
        check_eq("rst_reason", i0.halt_reason, 0);
        i0.run = 1'b0;
        rst_n = 1'b1;

        // load sequence from IDLE
        sw0 = blinker;
        i0.load = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            i0.load = 1'b0;
            check_eq($sformatf("load_rst_%0d", k), i0.life_rst, er[k]);
            check_eq($sformatf("load_clk_%0d", k), i0.life_clk, ec[k]);
        end
        check_eq("load_generation", i0.generation, 0);
        check_eq("load_halted", i0.halted, 0);

        // free-run blinker, period 5
        i0.period = 16'd5;
        i0.run = 1'b1;
        pulses = 0; last = 0;
        for (int k = 1; k <= 60 && pulses < 5; k++) begin
            @(negedge clk);
            if (i0.life_clk) begin
                if (pulses == 0) check_eq("run_first_tick", k, 6);
                else check_eq("run_interval", k - last, 8);
                check_eq("run_gen_at_tick", i0.generation, pulses);
                last = k;
                pulses++;
            end
        end
        check_eq("run_pulses", pulses, 5);
        i0.run = 1'b0;
        @(negedge clk);
        check_eq("drop_running_settle", i0.running, 1);
        repeat (2) @(negedge clk);
        check_eq("drop_running_idle", i0.running, 0);
        check_eq("drop_generation", i0.generation, 5);
        count_pulses(1'b0, 12, p);
        check_eq("drop_no_pulse", p, 0);

        // single cell dies
        load0(single);
        check_eq("single_gen0", i0.generation, 0);
        i0.step = 1'b1;
        count_pulses(1'b0, 6, p);
        i0.step = 1'b0;
        check_eq("extinct_pulses", p, 1);
        check_eq("extinct_halted", i0.halted, 1);
        check_eq("extinct_reason", i0.halt_reason, 1);
        check_eq("extinct_gen", i0.generation, 1);
        @(negedge clk);
        i0.step = 1'b1;
        i0.run = 1'b1;
        count_pulses(1'b0, 8, p);
        i0.step = 1'b0;
        i0.run = 1'b0;
        check_eq("halt_ignores_pulses", p, 0);
        check_eq("halt_holds_halted", i0.halted, 1);
        check_eq("halt_holds_gen", i0.generation, 1);

        // still-life block
        load0(block);
        check_eq("block_unhalted", i0.halted, 0);
        check_eq("block_reason_clr", i0.halt_reason, 0);
        i0.step = 1'b1;
        repeat (6) @(negedge clk);
        i0.step = 1'b0;
`ifdef LIFE_STABLE_HALT_EN
        check_eq("stable_halted", i0.halted, 1);
        check_eq("stable_reason", i0.halt_reason, 2);
        check_eq("stable_gen", i0.generation, 1);
`else
        check_eq("block_halted", i0.halted, 0);
        check_eq("block_gen", i0.generation, 1);
        i0.period = 16'd2;
        i0.run = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("block_run_gen", i0.generation, 4);
        check_eq("block_run_halted", i0.halted, 0);
        i0.run = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("block_final_gen", i0.generation, 5);
        check_eq("block_final_halted", i0.halted, 0);
`endif

        // generation limit with 3-bit counter, period 0 acts as 1
        load1(blinker);
        i1.period = '0;
        i1.run = 1'b1;
        pulses = 0; last = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (i1.life_clk) begin
                if (pulses == 1) check_eq("lim_interval", k - last, 4);
                last = k;
                pulses++;
            end
            if (i1.halted) break;
        end
        check_eq("lim_halted", i1.halted, 1);
        check_eq("lim_reason", i1.halt_reason, 3);
        check_eq("lim_gen", i1.generation, 7);
        check_eq("lim_pulses", pulses, 7);
        count_pulses(1'b1, 6, p);
        check_eq("lim_halt_run_ignored", p, 0);
        i1.run = 1'b0;
        load1(blinker);
        check_eq("lim_reload_gen", i1.generation, 0);
        check_eq("lim_reload_halted", i1.halted, 0);
        check_eq("lim_reload_reason", i1.halt_reason, 0);

        // reset mid-load
        i1.load = 1'b1;
        @(negedge clk);
        i1.load = 1'b0;
        @(negedge clk);
        check_eq("midload_clk", i1.life_clk, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midload_rst_clk", i1.life_clk, 0);
        check_eq("midload_rst_rst", i1.life_rst, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("after_rst_rst", i1.life_rst, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/life_sequencer.md
Name: life_sequencer

Overview:
Generation controller for the Game of Life field array. It produces the field's clock and load strobes (life_clk, life_rst) from the system clock, and supports load, single-step and free-run at a programmable rate. It counts generations and halts automatically on extinction or on generation-counter limit. It sits between user switches and the field array, and reads the field back for halt detection.

Parameters:
SIZE, 10, field edge length; field vector is SIZE*SIZE bits
DIV_WIDTH, 16, width of the run-rate period input
GEN_WIDTH, 16, width of the generation counter

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous, active-low reset
run  input  1  level; free-run while high
step  input  1  rising edge requests one generation
load  input  1  rising edge loads field from its switches
period  input  DIV_WIDTH  wait cycles between generations in run mode (0 treated as 1)
field  input  SIZE*SIZE  current field state, read back from the array
life_clk  output  1  registered clock to the field array; one-cycle high pulse per update
life_rst  output  1  registered load strobe to the field array
generation  output  GEN_WIDTH  generations since last load
running  output  1  high in RUN_WAIT/TICK/SETTLE/EVAL while in run mode
halted  output  1  high in HALT
halt_reason  output  2  00 none, 01 extinct, 10 stable, 11 generation limit

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset (rst_n=0 at posedge): state IDLE; all outputs 0; snapshot 0; edge-detect registers 0.
- step and load are edge-detected against a registered copy of each input.
- States: IDLE, LOAD_SETUP, LOAD_TICK, LOAD_HOLD, RUN_WAIT, TICK, SETTLE, EVAL, HALT.
- Load sequence:
  - A load edge in IDLE, RUN_WAIT or HALT goes to LOAD_SETUP (life_rst=1, life_clk=0).
  - LOAD_TICK: life_rst=1, life_clk=1.
  - LOAD_HOLD: life_rst=1, life_clk=0.
  - Then IDLE. On LOAD_HOLD exit: generation=0, halt_reason=00, snapshot<=field.
  - A load edge during TICK/SETTLE/EVAL is ignored; it is not queued.
- IDLE:
  - load edge has priority over step edge, which has priority over run.
  - step edge goes to TICK in single-step mode.
  - run=1 loads the wait counter with max(period,1)-1 and goes to RUN_WAIT.
- RUN_WAIT: counts down. At 0 go to TICK. run=0 returns to IDLE on the next cycle.
- TICK: life_clk=1 for exactly 1 cycle.
- SETTLE: life_clk=0, 1 cycle; the field is valid by the end of this cycle.
- EVAL (1 cycle): generation increments, wrapping is impossible (see limit). Then, in priority order:
  - field==0 → HALT, reason 01.
  - (optional) field==snapshot → HALT, reason 10.
  - generation reaches all-ones → HALT, reason 11.
  - Otherwise snapshot<=field. Go to RUN_WAIT (counter reloaded from current period) if in run mode and run=1; else IDLE.
- Run-mode timing: life_clk rising edges are exactly max(period,1)+3 cycles apart. period is sampled only on RUN_WAIT entry.
- Dropping run during TICK/SETTLE/EVAL completes the generation, then goes to IDLE.
- HALT: step and run are ignored. Only a load edge or reset leaves HALT. generation and halt_reason hold.
- life_clk and life_rst are driven straight from flops; there are no glitches.
- rst_n low in any state, including mid-load or mid-tick, forces IDLE next cycle with life_clk=life_rst=0.

Optional Feature:
LIFE_STABLE_HALT_EN:
- Defined: the EVAL field==snapshot check is active and halts with reason 10.
- Undefined: no comparison is made, and reason 10 is never produced. The snapshot register is still required for nothing else and may be removed.

Test Plan:
1. rst_n=0 for 2 cycles with run=1 → all outputs 0, no life_clk pulse while in reset.
2. load edge from IDLE → life_rst high exactly 3 cycles, life_clk high only in the 2nd; generation=0; halted=0.
3. Blinker loaded, period=5, run=1 for 40 cycles → life_clk rises every 8 cycles, generation counts 1,2,3…. Drop run mid-TICK → that generation completes, then IDLE.
4. Single live cell, step edge → one life_clk pulse, generation=1, halted=1, halt_reason=01. Further step edges → no pulse.
5. 2x2 block loaded, step: with LIFE_STABLE_HALT_EN → halt_reason=10, generation=1. Without it → no halt, run continues and generation keeps incrementing.
6. GEN_WIDTH=3, blinker, run, period=1 → halts at generation=7 with halt_reason=11. A load edge then clears generation to 0 and halted to 0.
